fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller of the asynchronous FIFO. It sits in the write clock domain directly upstream of the two-flop pointer synchronizer. It produces the registered Gray-coded write pointer that the synchronizer carries into the read domain. It also consumes the read pointer that the mirror-image synchronizer has already brought into this domain, and from it derives full, almost-full, fill level and overflow status.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/gray2bin.sv | 18 +
 rtl/fifo_wr_ctrl.sv | 79 +++++++
 tb/tb_fifo_wr_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: geometry shared by the async FIFO write controller, read
// controller and pointer synchronizers.
package fifo_pkg;

  localparam int FIFO_ADDR_W       = 3;
  localparam int FIFO_PTR_W        = FIFO_ADDR_W + 1;
  localparam int FIFO_AFULL_THRESH = 6;

endpackage : fifo_pkg

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter of parameterized width.
// Bit i of the binary value is the XOR of all Gray bits at or above i.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the parity of the Gray word shifted down to that bit.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule : gray2bin

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer and flag controller of the async FIFO.
// Produces the registered Gray write pointer for the synchronizer and derives
// full / almost-full / level / overflow from the synchronized read pointer.
// Level and full are pessimistic because the read pointer arrives late.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = FIFO_ADDR_W,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              wr_inc,
  input  logic [ADDR_W:0]   rd_ptr_sync,
  input  logic              ovf_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int P = ADDR_W + 1;
  localparam logic [P-1:0] AFULL_LVL = P'(AFULL_THRESH);
  // Full when the write pointer is one lap ahead: in Gray that means the two
  // top bits are inverted relative to the read pointer, the rest equal.
  localparam logic [P-1:0] FULL_MASK = P'(3) << (P - 2);

  logic [P-1:0] wbin;
  logic [P-1:0] wbin_next;
  logic [P-1:0] wgray_next;
  logic [P-1:0] rbin;
  logic [P-1:0] level_next;
  logic         full_next;
  logic         afull_next;
  logic         ovf_next;

  gray2bin #(
    .W(P)
  ) u_rd_g2b (
    .gray(rd_ptr_sync),
    .bin (rbin)
  );

  assign wr_en   = wr_inc & ~full;
  assign wr_addr = wbin[ADDR_W-1:0];

  // Next pointer, flags and level, re-evaluated every cycle even without a write.
  always_comb begin
    wbin_next  = wbin + {{ADDR_W{1'b0}}, wr_en};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_next  = (wgray_next == (rd_ptr_sync ^ FULL_MASK));
    level_next = wbin_next - rbin;
    afull_next = (level_next >= AFULL_LVL);
    ovf_next   = (wr_inc & full) | (overflow & ~ovf_clr);
  end

  // State register: pointers, flags, level and sticky overflow.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= wgray_next;
      full        <= full_next;
      almost_full <= afull_next;
      wr_level    <= level_next;
      overflow    <= ovf_next;
    end
  end

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: self-checking bench for fifo_wr_ctrl (ADDR_W=3, AFULL_THRESH=6).
// The reference model counts writes and reads as plain integers.
module tb_fifo_wr_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_inc = 1'b0;
  logic [3:0] rd_ptr_sync = 4'd0;
  logic       ovf_clr = 1'b0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  // Reference model: total writes accepted, total reads seen, derived flags.
  int m_wcnt = 0;
  int m_rcnt = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit m_ovf = 0;
  bit en_obs = 0;
  bit en_exp = 0;

  fifo_wr_ctrl dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .wr_inc     (wr_inc),
    .rd_ptr_sync(rd_ptr_sync),
    .ovf_clr    (ovf_clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_ptr_gray(wr_ptr_gray),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [3:0] to_gray(int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  // Drive one cycle from a negedge, capture wr_en, clock it, update the model.
  task automatic step(input bit inc, input bit clr, input int rcnt_new);
    wr_inc      = inc;
    ovf_clr     = clr;
    m_rcnt      = rcnt_new;
    rd_ptr_sync = to_gray(rcnt_new);
    #1;
    en_obs = wr_en;
    en_exp = inc && !m_full;
    @(posedge clk_in);
    if (en_exp) m_wcnt++;
    m_ovf   = (inc && m_full) || (m_ovf && !clr);
    m_level = m_wcnt - m_rcnt;
    m_full  = (m_level == 8);
    m_af    = (m_level >= 6);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    wr_inc = 1'b0;
    ovf_clr = 1'b0;
    rd_ptr_sync = 4'd0;
    m_wcnt = 0; m_rcnt = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    wr_inc = 1'b1;
    repeat (5) @(negedge clk_in);
    tests++;
    if ({wr_ptr_gray, wr_addr, wr_level, full, almost_full, overflow} !== 14'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got gray=%b addr=%0d lvl=%0d f=%b af=%b ovf=%b required all 0",
               wr_ptr_gray, wr_addr, wr_level, full, almost_full, overflow);
    end
    tests++;
    if (wr_en !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_wr_en: got %b required 1", wr_en);
    end
    wr_inc = 1'b0;
    rst_n = 1'b1;
    #2;
    tests++;
    if (wr_ptr_gray !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_release_gray: got %b required 0000", wr_ptr_gray);
    end
    m_wcnt = 0; m_rcnt = 0; m_level = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    @(negedge clk_in);
  endtask

  task automatic test_fill();
    logic [3:0] gray_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0);
      tests++;
      if (wr_ptr_gray !== gray_tbl[i]) begin
        fails++;
        $display("[TB] FAIL fill_gray[%0d]: got %b required %b", i, wr_ptr_gray, gray_tbl[i]);
      end
      tests++;
      if (almost_full !== (i >= 5)) begin
        fails++;
        $display("[TB] FAIL fill_afull[%0d]: got %b required %b", i, almost_full, (i >= 5));
      end
      tests++;
      if (full !== (i == 7) || wr_level !== 4'(i + 1)) begin
        fails++;
        $display("[TB] FAIL fill_full_level[%0d]: got f=%b lvl=%0d required f=%b lvl=%0d",
                 i, full, wr_level, (i == 7), i + 1);
      end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 0);
    tests++;
    if (en_obs !== 1'b0 || wr_ptr_gray !== 4'b1100 || overflow !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_blocked: got en=%b gray=%b ovf=%b required en=0 gray=1100 ovf=1",
               en_obs, wr_ptr_gray, overflow);
    end
    step(1'b0, 1'b1, 0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_clear: got %b required 0", overflow);
    end
    step(1'b1, 1'b1, 0);
    tests++;
    if (overflow !== 1'b1 || wr_ptr_gray !== 4'b1100) begin
      fails++;
      $display("[TB] FAIL ovf_set_wins: got ovf=%b gray=%b required ovf=1 gray=1100",
               overflow, wr_ptr_gray);
    end
  endtask

  task automatic test_drain();
    step(1'b0, 1'b0, 4);
    tests++;
    if (full !== 1'b0 || almost_full !== 1'b0 || wr_level !== 4'd4) begin
      fails++;
      $display("[TB] FAIL drain: got f=%b af=%b lvl=%0d required f=0 af=0 lvl=4",
               full, almost_full, wr_level);
    end
  endtask

  task automatic test_wrap();
    bit         addr_wrapped = 0;
    bit         gray_wrapped = 0;
    bit         saw_full = 0;
    bit         level_bad = 0;
    logic [2:0] prev_addr;
    logic [3:0] prev_gray;
    do_reset();
    repeat (3) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      prev_addr = wr_addr;
      prev_gray = wr_ptr_gray;
      step(1'b1, 1'b0, m_wcnt - 2);
      if (prev_addr == 3'd7 && wr_addr == 3'd0) addr_wrapped = 1;
      if (prev_gray == 4'b1000 && wr_ptr_gray == 4'b0000) gray_wrapped = 1;
      if (full) saw_full = 1;
      if (wr_level !== 4'd3) level_bad = 1;
    end
    tests++;
    if (!addr_wrapped || !gray_wrapped) begin
      fails++;
      $display("[TB] FAIL wrap_seen: got addr_wrap=%b gray_wrap=%b required 1 1", addr_wrapped, gray_wrapped);
    end
    tests++;
    if (saw_full || level_bad) begin
      fails++;
      $display("[TB] FAIL wrap_level: got full_seen=%b level_bad=%b required 0 0", saw_full, level_bad);
    end
    tests++;
    if (wr_addr !== 3'(m_wcnt) || wr_ptr_gray !== to_gray(m_wcnt)) begin
      fails++;
      $display("[TB] FAIL wrap_final_ptr: got addr=%0d gray=%b required addr=%0d gray=%b",
               wr_addr, wr_ptr_gray, 3'(m_wcnt), to_gray(m_wcnt));
    end
  endtask

  task automatic test_random();
    int  rc;
    bit  inc;
    bit  clr;
    do_reset();
    rc = 0;
    for (int i = 0; i < 400; i++) begin
      inc = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) rc = rc + $urandom_range(1, 3);
      if (rc > m_wcnt) rc = m_wcnt;
      step(inc, clr, rc);
      tests++;
      if (en_obs !== en_exp) begin
        fails++;
        $display("[TB] FAIL rand_wr_en[%0d]: got %b required %b", i, en_obs, en_exp);
      end
      tests++;
      if (wr_ptr_gray !== to_gray(m_wcnt) || wr_addr !== 3'(m_wcnt)) begin
        fails++;
        $display("[TB] FAIL rand_ptr[%0d]: got gray=%b addr=%0d required gray=%b addr=%0d",
                 i, wr_ptr_gray, wr_addr, to_gray(m_wcnt), 3'(m_wcnt));
      end
      tests++;
      if (wr_level !== 4'(m_level) || full !== m_full || almost_full !== m_af || overflow !== m_ovf) begin
        fails++;
        $display("[TB] FAIL rand_flags[%0d]: got lvl=%0d f=%b af=%b ovf=%b required lvl=%0d f=%b af=%b ovf=%b",
                 i, wr_level, full, almost_full, overflow, m_level, m_full, m_af, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
